// File: rtl/calc2_req_agent.sv
// calc2 request initiator: accepts client ops, allocates tags, serialises cmd/data2
// onto the request port, matches responses by tag and polices timeouts/unexpected tags.
module calc2_req_agent #(
    parameter int unsigned TIMEOUT         = 255,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_data1,
    input  logic [0:31] op_data2,
    output logic [0:1]  op_tag,
    output logic [0:3]  req_cmd,
    output logic [0:31] req_data,
    output logic [0:1]  req_tag,
    input  logic [0:1]  out_resp,
    input  logic [0:31] out_data,
    input  logic [0:1]  out_tag,
    output logic        res_valid,
    output logic [0:1]  res_resp,
    output logic [0:31] res_data,
    output logic [0:1]  res_tag,
    output logic [0:2]  outstanding,
    output logic        err_unexp,
    output logic [0:3]  err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA2} state_e;
    typedef enum logic [1:0] {T_FREE, T_BUSY, T_QUAR} tag_e;

    state_e      state_q, state_d;
    tag_e        tag_q   [4];
    tag_e        tag_d   [4];
    logic [7:0]  timer_q [4];
    logic [7:0]  timer_d [4];

    logic [3:0]  cmd_q;
    logic [31:0] data1_q, data2_q;
    logic [1:0]  atag_q;

    logic        res_valid_q;
    logic [1:0]  res_resp_q, res_tag_q;
    logic [31:0] res_data_q;
    logic [2:0]  outst_q, outst_d;
    logic        err_unexp_q;
    logic [0:3]  err_to_q, err_to_d;

    logic        any_free, avail, accept, resp_hit, resp_bad;
    logic [1:0]  free_idx;

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (tag_q[i-1] == T_FREE) begin
                any_free = 1'b1;
                free_idx = 2'(i - 1);
            end
        end
    end

    // Availability looks only at registered tag state, never at this cycle's response.
    assign avail    = any_free && (32'(outst_q) < MAX_OUTSTANDING);
    assign accept   = op_valid && op_ready;
    assign resp_hit = (out_resp != 2'd0) && (tag_q[out_tag] == T_BUSY);
    assign resp_bad = (out_resp != 2'd0) && !resp_hit;

    always_ff @(posedge c_clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_CMD : S_IDLE;
            S_CMD:   state_d = S_DATA2;
            S_DATA2: state_d = accept ? S_CMD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready = 1'b0;
        req_cmd  = '0;
        req_data = '0;
        req_tag  = '0;
        case (state_q)
            S_IDLE:  op_ready = reset && avail;
            S_CMD: begin
                req_cmd  = cmd_q;
                req_data = data1_q;
                req_tag  = atag_q;
            end
            S_DATA2: begin
                op_ready = reset && avail;
                req_data = data2_q;
            end
            default: ;
        endcase
    end

    // A response landing on the timeout edge frees the tag instead of quarantining it.
    always_comb begin
        err_to_d = err_to_q;
        outst_d  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            tag_d[i]   = tag_q[i];
            timer_d[i] = timer_q[i];
            if (state_q == S_CMD && atag_q == 2'(i)) begin
                timer_d[i] = '0;
            end else if (tag_q[i] == T_BUSY) begin
                timer_d[i] = timer_q[i] + 8'd1;
                if (!(resp_hit && out_tag == 2'(i)) && 32'(timer_q[i]) == TIMEOUT - 1) begin
                    tag_d[i]    = T_QUAR;
                    err_to_d[i] = 1'b1;
                end
            end
            if (resp_hit && out_tag == 2'(i)) tag_d[i] = T_FREE;
            if (accept && free_idx == 2'(i))  tag_d[i] = T_BUSY;
            if (tag_d[i] != T_FREE)           outst_d  = outst_d + 3'd1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                tag_q[i]   <= T_FREE;
                timer_q[i] <= '0;
            end
            cmd_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            atag_q      <= '0;
            res_valid_q <= 1'b0;
            res_resp_q  <= '0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            outst_q     <= '0;
            err_unexp_q <= 1'b0;
            err_to_q    <= '0;
        end else begin
            tag_q    <= tag_d;
            timer_q  <= timer_d;
            outst_q  <= outst_d;
            err_to_q <= err_to_d;
            if (accept) begin
                cmd_q   <= op_cmd;
                data1_q <= op_data1;
                data2_q <= op_data2;
                atag_q  <= free_idx;
            end
            res_valid_q <= resp_hit;
            if (resp_hit) begin
                res_resp_q <= out_resp;
                res_data_q <= out_data;
                res_tag_q  <= out_tag;
            end
            if (resp_bad) err_unexp_q <= 1'b1;
        end
    end

    assign op_tag      = free_idx;
    assign res_valid   = res_valid_q;
    assign res_resp    = res_resp_q;
    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign outstanding = outst_q;
    assign err_unexp   = err_unexp_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_calc2_req_agent.sv
// Bench for calc2_req_agent: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a tag/deadline reference model.
module tb_calc2_req_agent;

    localparam int TO   = 8;
    localparam int MAXO = 4;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [0:3]  op_cmd = '0;
    logic [0:31] op_data1 = '0;
    logic [0:31] op_data2 = '0;
    logic [0:1]  op_tag;
    logic [0:3]  req_cmd;
    logic [0:31] req_data;
    logic [0:1]  req_tag;
    logic [0:1]  out_resp = '0;
    logic [0:31] out_data = '0;
    logic [0:1]  out_tag = '0;
    logic        res_valid;
    logic [0:1]  res_resp;
    logic [0:31] res_data;
    logic [0:1]  res_tag;
    logic [0:2]  outstanding;
    logic        err_unexp;
    logic [0:3]  err_timeout;

    always #5 c_clk = ~c_clk;

    calc2_req_agent #(.TIMEOUT(TO), .MAX_OUTSTANDING(MAXO)) dut (
        .c_clk(c_clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2), .op_tag(op_tag),
        .req_cmd(req_cmd), .req_data(req_data), .req_tag(req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .res_valid(res_valid), .res_resp(res_resp), .res_data(res_data), .res_tag(res_tag),
        .outstanding(outstanding), .err_unexp(err_unexp), .err_timeout(err_timeout)
    );

    typedef struct {
        bit          rst;
        bit          val;
        logic [3:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  resp;
        logic [31:0] od;
        logic [1:0]  ot;
    } in_t;

    typedef struct {
        in_t         stim;
        bit          e_rdy;
        logic [1:0]  e_tag;
        logic [3:0]  e_rcmd;
        logic [31:0] e_rdata;
        logic [1:0]  e_rtag;
        bit          e_rv;
        logic [1:0]  e_rresp;
        logic [31:0] e_resd;
        logic [1:0]  e_restag;
        logic [2:0]  e_out;
        bit          e_unexp;
    } vec_t;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: tag status 0=free 1=busy 2=quarantined, absolute deadline edge per tag,
    // and the expected request-port contents keyed by cycle number.
    int          mstat [4];
    int          mdead [4];
    int          cyc = 0;
    int          last_acc = -10;
    bit          m_rv = 1'b0;
    logic [1:0]  m_rresp = '0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rtag = '0;
    bit          m_unexp = 1'b0;
    logic [0:3]  m_to = '0;
    logic [3:0]  q_cmd  [int];
    logic [31:0] q_data [int];
    logic [1:0]  q_tag  [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 4; i++) if (mstat[i] != 0) n++;
        return n;
    endfunction

    function automatic int m_low();
        for (int i = 0; i < 4; i++) if (mstat[i] == 0) return i;
        return 0;
    endfunction

    function automatic bit m_ready(input bit rst);
        return rst && (last_acc != cyc - 1) && (m_count() < 4) && (m_count() < MAXO);
    endfunction

    task automatic model_check();
        bit r;
        r = m_ready(reset);
        chk("op_ready", 32'(op_ready), 32'(r));
        if (r) chk("op_tag", 32'(op_tag), 32'(m_low()));
        chk("req_cmd",  32'(req_cmd),  q_cmd.exists(cyc)  ? 32'(q_cmd[cyc])  : 32'd0);
        chk("req_data", 32'(req_data), q_data.exists(cyc) ? q_data[cyc]      : 32'd0);
        chk("req_tag",  32'(req_tag),  q_tag.exists(cyc)  ? 32'(q_tag[cyc])  : 32'd0);
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        if (m_rv) begin
            chk("res_resp", 32'(res_resp), 32'(m_rresp));
            chk("res_data", 32'(res_data), m_rdata);
            chk("res_tag",  32'(res_tag),  32'(m_rtag));
        end
        chk("outstanding", 32'(outstanding), 32'(m_count()));
        chk("err_unexp",   32'(err_unexp),   32'(m_unexp));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
    endtask

    task automatic model_step(input in_t v);
        bit acc;
        int t, hit;
        acc = v.val && m_ready(v.rst);
        t   = m_low();
        if (!v.rst) begin
            for (int i = 0; i < 4; i++) mstat[i] = 0;
            m_rv = 1'b0; m_rresp = '0; m_rdata = '0; m_rtag = '0;
            m_unexp = 1'b0; m_to = '0;
            q_cmd.delete(); q_data.delete(); q_tag.delete();
            last_acc = -10;
        end else begin
            hit  = -1;
            m_rv = 1'b0;
            if (v.resp != 2'd0) begin
                if (mstat[v.ot] == 1) begin
                    hit = int'(v.ot);
                    m_rv = 1'b1; m_rresp = v.resp; m_rdata = v.od; m_rtag = v.ot;
                end else begin
                    m_unexp = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++)
                if (mstat[i] == 1 && i != hit && cyc == mdead[i]) begin
                    mstat[i] = 2;
                    m_to[i]  = 1'b1;
                end
            if (hit >= 0) mstat[hit] = 0;
            if (acc) begin
                mstat[t] = 1;
                mdead[t] = cyc + 1 + TO;
                q_cmd[cyc+1] = v.cmd;  q_data[cyc+1] = v.d1; q_tag[cyc+1] = 2'(t);
                q_cmd[cyc+2] = 4'd0;   q_data[cyc+2] = v.d2; q_tag[cyc+2] = 2'd0;
                last_acc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic tick(input bit chk_en, input in_t v);
        @(negedge c_clk);
        reset = v.rst; op_valid = v.val; op_cmd = v.cmd; op_data1 = v.d1; op_data2 = v.d2;
        out_resp = v.resp; out_data = v.od; out_tag = v.ot;
        #1;
        if (chk_en) model_check();
        model_step(v);
    endtask

    function automatic vec_t row(input int rst, val, cmd, d1, d2, resp, od, ot,
                                 rdy, tg, rcmd, rdata, rtag, rv, rresp, resd, restag, outs, unexp);
        vec_t r;
        r.stim.rst = 1'(rst); r.stim.val = 1'(val); r.stim.cmd = 4'(cmd);
        r.stim.d1 = 32'(d1); r.stim.d2 = 32'(d2); r.stim.resp = 2'(resp);
        r.stim.od = 32'(od); r.stim.ot = 2'(ot);
        r.e_rdy = 1'(rdy); r.e_tag = 2'(tg); r.e_rcmd = 4'(rcmd); r.e_rdata = 32'(rdata);
        r.e_rtag = 2'(rtag); r.e_rv = 1'(rv); r.e_rresp = 2'(rresp); r.e_resd = 32'(resd);
        r.e_restag = 2'(restag); r.e_out = 3'(outs); r.e_unexp = 1'(unexp);
        return r;
    endfunction

    initial begin
        vec_t tbl [12];
        in_t  idle, v;
        idle = '{rst: 1'b1, val: 1'b0, cmd: 4'd0, d1: 32'd0, d2: 32'd0, resp: 2'd0, od: 32'd0, ot: 2'd0};
        for (int i = 0; i < 4; i++) begin mstat[i] = 0; mdead[i] = 0; end

        //            rst val cmd d1 d2 rsp od ot | rdy tag rcmd rdata rtag rv rresp resd restag out unexp
        tbl[0]  = row(0, 1, 1, 5, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = row(0, 1, 1, 5, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = row(0, 1, 1, 5, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = row(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = row(1, 1, 1, 5, 3, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = row(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 0);
        tbl[6]  = row(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = row(1, 0, 0, 0, 0, 1, 8, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = row(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
        tbl[9]  = row(1, 0, 0, 0, 0, 2, 0, 3,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = row(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[11] = row(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        v = idle; v.rst = 1'b0;
        tick(1'b0, v);

        for (int i = 0; i < 12; i++) begin
            tick(1'b1, tbl[i].stim);
            chk($sformatf("t%0d_ready", i), 32'(op_ready), 32'(tbl[i].e_rdy));
            if (tbl[i].e_rdy) chk($sformatf("t%0d_tag", i), 32'(op_tag), 32'(tbl[i].e_tag));
            chk($sformatf("t%0d_req_cmd", i),  32'(req_cmd), 32'(tbl[i].e_rcmd));
            chk($sformatf("t%0d_req_data", i), 32'(req_data), tbl[i].e_rdata);
            chk($sformatf("t%0d_req_tag", i),  32'(req_tag), 32'(tbl[i].e_rtag));
            chk($sformatf("t%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) begin
                chk($sformatf("t%0d_res_resp", i), 32'(res_resp), 32'(tbl[i].e_rresp));
                chk($sformatf("t%0d_res_data", i), 32'(res_data), tbl[i].e_resd);
                chk($sformatf("t%0d_res_tag", i),  32'(res_tag), 32'(tbl[i].e_restag));
            end
            chk($sformatf("t%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
            chk($sformatf("t%0d_err_unexp", i), 32'(err_unexp), 32'(tbl[i].e_unexp));
            chk($sformatf("t%0d_err_timeout", i), 32'(err_timeout), 32'd0);
        end

        // Tag exhaustion, free-then-reuse, and a response landing on a tag's timeout edge.
        v = idle; v.rst = 1'b0;
        tick(1'b1, v);
        for (int k = 0; k < 4; k++) begin
            v = idle; v.val = 1'b1; v.cmd = 4'(k + 1); v.d1 = $urandom; v.d2 = $urandom;
            tick(1'b1, v);
            chk("exh_ready", 32'(op_ready), 32'd1);
            chk("exh_tag", 32'(op_tag), 32'(k));
            tick(1'b1, v);
            chk("exh_cmd_busy", 32'(op_ready), 32'd0);
        end
        v = idle; v.val = 1'b1; v.resp = 2'd1; v.od = 32'h22; v.ot = 2'd2;
        tick(1'b1, v);
        chk("full_ready", 32'(op_ready), 32'd0);
        v = idle; v.val = 1'b1; v.cmd = 4'd5; v.d1 = 32'hAA; v.d2 = 32'd4;
        tick(1'b1, v);
        chk("reuse_ready", 32'(op_ready), 32'd1);
        chk("reuse_tag", 32'(op_tag), 32'd2);
        chk("reuse_res_tag", 32'(res_tag), 32'd2);
        tick(1'b1, v);
        v = idle; v.val = 1'b1; v.resp = 2'd3; v.od = 32'h11; v.ot = 2'd1;
        tick(1'b1, v);
        chk("samecyc_before", 32'(op_ready), 32'd0);
        v = idle; v.val = 1'b1;
        tick(1'b1, v);
        chk("samecyc_ready", 32'(op_ready), 32'd1);
        chk("samecyc_tag", 32'(op_tag), 32'd1);
        chk("edge_resp_wins", 32'(res_valid), 32'd1);
        chk("tag0_timed_out", 32'(err_timeout), 32'b1000);
        for (int k = 0; k < 3; k++) tick(1'b1, idle);

        // Clean timeout on tag 0, then a late response on it.
        v = idle; v.rst = 1'b0;
        tick(1'b1, v);
        v = idle; v.val = 1'b1; v.cmd = 4'd2; v.d1 = 32'd9; v.d2 = 32'd1;
        tick(1'b1, v);
        chk("to_tag", 32'(op_tag), 32'd0);
        for (int k = 0; k < TO + 1; k++) begin
            tick(1'b1, idle);
            chk("to_not_yet", 32'(err_timeout), 32'd0);
        end
        tick(1'b1, idle);
        chk("to_flag", 32'(err_timeout), 32'b1000);
        chk("to_outstanding", 32'(outstanding), 32'd1);
        chk("to_next_tag", 32'(op_tag), 32'd1);
        v = idle; v.resp = 2'd1; v.od = 32'h77; v.ot = 2'd0;
        tick(1'b1, v);
        tick(1'b1, idle);
        chk("late_res_valid", 32'(res_valid), 32'd0);
        chk("late_unexp", 32'(err_unexp), 32'd1);

        // Randomized traffic with occasional resets.
        v = idle; v.rst = 1'b0;
        tick(1'b1, v);
        for (int n = 0; n < 3000; n++) begin
            v.rst  = ($urandom_range(0, 149) != 0);
            v.val  = ($urandom_range(0, 3) != 0);
            v.cmd  = 4'($urandom_range(0, 15));
            v.d1   = $urandom;
            v.d2   = $urandom;
            v.resp = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.od   = $urandom;
            v.ot   = 2'($urandom_range(0, 3));
            tick(1'b1, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
